// File: rtl/calc_sequencer.sv
// calc_sequencer
//   Sequences a shared ALU from decoded keypad presses. Two decimal operands
//   and an operator are accumulated. One start/done transaction is issued to
//   the ALU, and the result is then held for display.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   key_valid, key      : one-cycle key strobe and key code
//                         (0-9 digit, A add, B sub, C mul, D div, E equals, F clear)
//   alu_start           : one-cycle request to the ALU (high in EXEC)
//   alu_op, alu_a, alu_b: registered operator/operands, stable through EXEC and WAIT
//   alu_done, alu_result, alu_err : ALU completion strobe with result and error
//   disp_value          : registered display value (a, b or result, zero-extended)
//   busy                : high in EXEC and WAIT
//   err                 : sticky error, cleared on next entry
//   state               : current state encoding (ENTER_A=0 .. SHOW=4)
//
// Handshake: alu_start is a single-cycle request. alu_done is a single-cycle
// response that is only honoured while in WAIT. A done strobe at any other
// time, including after an abort or a timeout, is dropped.
module calc_sequencer #(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_valid,
  input  logic [3:0]           key,
  output logic                 alu_start,
  output logic [1:0]           alu_op,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic                 alu_done,
  input  logic [2*WIDTH-1:0]   alu_result,
  input  logic                 alu_err,
  output logic [2*WIDTH-1:0]   disp_value,
  output logic                 busy,
  output logic                 err,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_EXEC    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_SHOW    = 3'd4
  } state_t;

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]    MAX_CNT  = CW'(MAX_DIGITS);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] TEN      = WIDTH'(10);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [CW-1:0]        cnt_a_q, cnt_a_d;
  logic [CW-1:0]        cnt_b_q, cnt_b_d;
  logic [1:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 err_q, err_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [2*WIDTH-1:0]   disp_q, disp_d;

  // Key decode
  logic             is_digit, is_op, is_eq, is_clr;
  logic [WIDTH-1:0] digit_val;
  logic [1:0]       key_op;

  assign is_digit  = key_valid && (key <= 4'd9);
  assign is_op     = key_valid && (key >= 4'd10) && (key <= 4'd13);
  assign is_eq     = key_valid && (key == 4'd14);
  assign is_clr    = key_valid && (key == 4'd15);
  assign digit_val = WIDTH'(key);
  // A..D map to 00..11 by offsetting from key code 10
  assign key_op    = 2'(key - 4'd10);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;
    timer_d  = timer_q;

    unique case (state_q)
      ST_ENTER_A: begin
        if (is_digit) begin
          if (cnt_a_q < MAX_CNT) begin
            a_d     = a_q * TEN + digit_val;
            cnt_a_d = cnt_a_q + CW'(1);
          end
        end else if (is_op) begin
          op_d    = key_op;
          state_d = ST_ENTER_B;
        end else if (is_clr) begin
          a_d     = '0;
          b_d     = '0;
          cnt_a_d = '0;
          cnt_b_d = '0;
          err_d   = 1'b0;
        end
      end

      ST_ENTER_B: begin
        if (is_digit) begin
          if (cnt_b_q < MAX_CNT) begin
            b_d     = b_q * TEN + digit_val;
            cnt_b_d = cnt_b_q + CW'(1);
          end
        end else if (is_op) begin
          op_d = key_op;
        end else if (is_eq) begin
          if (cnt_b_q != '0) state_d = ST_EXEC;
        end else if (is_clr) begin
          a_d     = '0;
          b_d     = '0;
          cnt_a_d = '0;
          cnt_b_d = '0;
          err_d   = 1'b0;
          state_d = ST_ENTER_A;
        end
      end

      ST_EXEC: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // Abort has priority over a coincident completion
        if (is_clr) begin
          a_d     = '0;
          b_d     = '0;
          cnt_a_d = '0;
          cnt_b_d = '0;
          err_d   = 1'b0;
          state_d = ST_ENTER_A;
        end else if (alu_done) begin
          result_d = alu_result;
          err_d    = alu_err;
          state_d  = ST_SHOW;
        end else if (timer_q == TMO_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_SHOW;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_SHOW: begin
        if (is_digit) begin
          a_d     = digit_val;
          cnt_a_d = CW'(1);
          b_d     = '0;
          cnt_b_d = '0;
          err_d   = 1'b0;
          state_d = ST_ENTER_A;
        end else if (is_op) begin
          // Chain only a clean result that fits back into an operand
          if (!err_q && (result_q[2*WIDTH-1:WIDTH] == '0)) begin
            a_d     = result_q[WIDTH-1:0];
            cnt_a_d = MAX_CNT;
            b_d     = '0;
            cnt_b_d = '0;
            op_d    = key_op;
            state_d = ST_ENTER_B;
          end
        end else if (is_clr) begin
          a_d     = '0;
          b_d     = '0;
          cnt_a_d = '0;
          cnt_b_d = '0;
          err_d   = 1'b0;
          state_d = ST_ENTER_A;
        end
      end

      default: state_d = ST_ENTER_A;
    endcase

    // Display follows the next state so it lands one cycle after the event
    unique case (state_d)
      ST_ENTER_A: disp_d = {{WIDTH{1'b0}}, a_d};
      ST_SHOW:    disp_d = result_d;
      default:    disp_d = {{WIDTH{1'b0}}, b_d};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_ENTER_A;
      a_q      <= '0;
      b_q      <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      op_q     <= 2'b00;
      result_q <= '0;
      err_q    <= 1'b0;
      timer_q  <= '0;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
      disp_q   <= disp_d;
    end
  end

  assign alu_start  = (state_q == ST_EXEC);
  assign busy       = (state_q == ST_EXEC) || (state_q == ST_WAIT);
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign disp_value = disp_q;
  assign err        = err_q;
  assign state      = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer (WIDTH=8, MAX_DIGITS=2, TIMEOUT=16).
module tb_calc_sequencer;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           key_valid = 1'b0;
  logic [3:0]     key = 4'd0;
  logic           alu_start;
  logic [1:0]     alu_op;
  logic [W-1:0]   alu_a, alu_b;
  logic           alu_done = 1'b0;
  logic [2*W-1:0] alu_result = '0;
  logic           alu_err = 1'b0;
  logic [2*W-1:0] disp_value;
  logic           busy, err;
  logic [2:0]     state;

  calc_sequencer #(.WIDTH(W), .MAX_DIGITS(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key(key),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .disp_value(disp_value), .busy(busy), .err(err), .state(state)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard state
  int n_pass  = 0;
  int n_total = 0;
  logic [2*W+1:0] exp_start_q[$];   // {op, a, b} per expected alu_start pulse
  logic [2*W:0]   exp_show_q[$];    // {err, disp} per expected SHOW entry
  logic [2:0]     prev_state = 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Driver tasks: called at posedge+1, return at posedge+1
  task automatic press(input logic [3:0] k);
    key = k;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic done_pulse(input logic [2*W-1:0] res, input logic e);
    alu_result = res;
    alu_err = e;
    alu_done = 1'b1;
    @(posedge clk); #1;
    alu_done = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a start or a result
  always @(negedge clk) begin
    if (!reset) begin
      if (alu_start) begin
        if (exp_start_q.size() == 0) begin
          n_total++;
          $display("FAIL start_unexpected: got alu_start=1 expected no request");
        end else begin
          logic [2*W+1:0] e;
          e = exp_start_q.pop_front();
          check("start_op", alu_op, e[2*W+1:2*W]);
          check("start_a", alu_a, e[2*W-1:W]);
          check("start_b", alu_b, e[W-1:0]);
        end
      end
      if (state == 3'd4 && prev_state != 3'd4) begin
        if (exp_show_q.size() == 0) begin
          n_total++;
          $display("FAIL show_unexpected: got SHOW entry expected none");
        end else begin
          logic [2*W:0] e;
          e = exp_show_q.pop_front();
          check("show_disp", disp_value, e[2*W-1:0]);
          check("show_err", err, e[2*W]);
        end
      end
    end
    prev_state = state;
  end

  int wait_cnt;

  initial begin
    // Reset
    idle(2);
    reset = 1'b0;
    check("rst_state", state, 0);
    check("rst_disp", disp_value, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_start", alu_start, 0);
    check("rst_op", alu_op, 0);
    check("rst_a", alu_a, 0);
    check("rst_b", alu_b, 0);

    // 12 + 34 = 46
    press(4'd1); press(4'd2);
    check("a12_disp", disp_value, 12);
    press(4'hA);
    check("enter_b_state", state, 1);
    check("enter_b_disp", disp_value, 0);
    press(4'd3); press(4'd4);
    check("b34_disp", disp_value, 34);
    exp_start_q.push_back({2'd0, 8'd12, 8'd34});
    exp_show_q.push_back({1'b0, 16'd46});
    press(4'hE);
    check("exec_state", state, 2);
    check("exec_busy", busy, 1);
    idle(1);
    check("wait_state", state, 3);
    check("wait_start_low", alu_start, 0);
    idle(1);
    done_pulse(16'd46, 1'b0);
    check("add_state", state, 4);
    check("add_disp", disp_value, 46);
    check("add_busy", busy, 0);

    // Chain: 46 - 6 = 40
    press(4'hB);
    check("chain_state", state, 1);
    press(4'd6);
    exp_start_q.push_back({2'd1, 8'd46, 8'd6});
    exp_show_q.push_back({1'b0, 16'd40});
    press(4'hE);
    idle(2);
    done_pulse(16'd40, 1'b0);
    check("sub_disp", disp_value, 40);

    // Digit limit: 1,2,3 -> 12; E ignored in ENTER_A
    press(4'd1); press(4'd2); press(4'd3);
    check("limit_disp", disp_value, 12);
    press(4'hE);
    check("eq_ignored_state", state, 0);
    press(4'hF);
    check("clear_disp", disp_value, 0);

    // 9 / 0 with ALU error
    press(4'd9); press(4'hD); press(4'd0);
    exp_start_q.push_back({2'd3, 8'd9, 8'd0});
    exp_show_q.push_back({1'b1, 16'd255});
    press(4'hE);
    idle(1);
    done_pulse(16'd255, 1'b1);
    press(4'hB);
    check("err_chain_state", state, 4);
    check("err_chain_err", err, 1);
    press(4'd5);
    check("digit_after_err_state", state, 0);
    check("digit_after_err_disp", disp_value, 5);
    check("digit_after_err_err", err, 0);

    // Timeout: 5 * 3, no done
    press(4'hC); press(4'd3);
    exp_start_q.push_back({2'd2, 8'd5, 8'd3});
    exp_show_q.push_back({1'b1, 16'd0});
    press(4'hE);
    idle(1);
    wait_cnt = 0;
    while (state == 3'd3 && wait_cnt < 100) begin
      wait_cnt++;
      idle(1);
    end
    check("timeout_wait_cycles", wait_cnt, 16);
    check("timeout_state", state, 4);
    check("timeout_err", err, 1);
    check("timeout_disp", disp_value, 0);
    done_pulse(16'd99, 1'b0);
    check("late_done_disp", disp_value, 0);
    check("late_done_state", state, 4);

    // Abort in WAIT with coincident done
    press(4'd4); press(4'hA); press(4'd3);
    exp_start_q.push_back({2'd0, 8'd4, 8'd3});
    press(4'hE);
    idle(2);
    key = 4'hF; key_valid = 1'b1;
    alu_result = 16'd7; alu_err = 1'b0; alu_done = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0; alu_done = 1'b0;
    check("abort_state", state, 0);
    check("abort_disp", disp_value, 0);
    check("abort_a", alu_a, 0);

    // Wide result blocks chaining: 20 * 15 = 300
    press(4'd2); press(4'd0); press(4'hC); press(4'd1); press(4'd5);
    exp_start_q.push_back({2'd2, 8'd20, 8'd15});
    exp_show_q.push_back({1'b0, 16'd300});
    press(4'hE);
    idle(1);
    done_pulse(16'd300, 1'b0);
    press(4'hA);
    check("wide_chain_state", state, 4);
    check("wide_chain_disp", disp_value, 300);
    done_pulse(16'd5, 1'b0);
    check("done_outside_wait", disp_value, 300);

    // Reset mid-WAIT
    press(4'hF);
    press(4'd2); press(4'hA); press(4'd2);
    exp_start_q.push_back({2'd0, 8'd2, 8'd2});
    press(4'hE);
    idle(2);
    #2 reset = 1'b1;
    #1;
    check("midwait_rst_state", state, 0);
    check("midwait_rst_start", alu_start, 0);
    check("midwait_rst_busy", busy, 0);
    idle(1);
    reset = 1'b0;
    idle(2);

    check("start_q_drained", exp_start_q.size(), 0);
    check("show_q_drained", exp_show_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Sequences the shared ALU from decoded keypad presses. It accumulates two decimal operands and an operator, issues one start/done transaction to the ALU, and holds the result for display. It sits between the keypad controller (key code plus one-cycle press strobe) and the ALU datapath, and also drives the display value and status LEDs.

Parameters:
WIDTH, 8, operand width in bits
MAX_DIGITS, 2, maximum decimal digits per operand (10^MAX_DIGITS-1 must fit in WIDTH)
TIMEOUT, 1024, cycles to wait for alu_done before aborting with error

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
key_valid  input  1  one-cycle strobe, one per key press (already debounced)
key  input  4  key code: 0-9 digit, A add, B sub, C mul, D div, E equals, F clear
alu_start  output  1  one-cycle request to the ALU
alu_op  output  2  00 add, 01 sub, 10 mul, 11 div
alu_a  output  WIDTH  operand A
alu_b  output  WIDTH  operand B
alu_done  input  1  one-cycle completion strobe from the ALU
alu_result  input  2*WIDTH  ALU result, valid with alu_done
alu_err  input  1  ALU error (e.g. divide by zero), valid with alu_done
disp_value  output  2*WIDTH  binary value to display
busy  output  1  high in EXEC and WAIT
err  output  1  sticky error, cleared on next entry
state  output  3  current state encoding, for LEDs

Behaviour:
- Reset, asynchronous: state=ENTER_A; a=b=0; digit counts 0; alu_start=0; alu_op=00; result=0; err=0; timer=0.
- Keys are acted on only in the cycle where key_valid=1.
- States: ENTER_A=0, ENTER_B=1, EXEC=2, WAIT=3, SHOW=4.
- Digit accumulation is identical for a and b: value <= value*10+d if count<MAX_DIGITS, then count++. Otherwise the digit is ignored silently.
- ENTER_A:
  - digit: accumulate a.
  - A-D: latch op, go to ENTER_B. This is allowed with zero digits entered (a=0).
  - E: ignored.
  - F: clear a, b, counts and err; stay in ENTER_A.
- ENTER_B:
  - digit: accumulate b.
  - A-D: replace the latched op.
  - E: if b count=0, ignored; else go to EXEC.
  - F: full clear, go to ENTER_A.
- EXEC: alu_start=1 for exactly this one cycle, then go to WAIT. Clear timer.
- alu_a, alu_b and alu_op are register outputs. They are stable from EXEC entry until WAIT exit.
- WAIT:
  - Timer increments each cycle.
  - alu_done: result <= alu_result, err <= alu_err, go to SHOW.
  - Timer reaching TIMEOUT-1 without done: result=0, err=1, go to SHOW.
  - F: abort. Full clear, go to ENTER_A. A later alu_done is ignored.
  - All other keys are ignored.
  - F and alu_done in the same cycle: F wins.
- SHOW:
  - digit: a=d, count_a=1, b=0, err=0, go to ENTER_A.
  - A-D: chaining. If err=0 and result<2^WIDTH, then a<=result[WIDTH-1:0], count_a=MAX_DIGITS, b=0, latch op, go to ENTER_B. Otherwise ignored.
  - E: ignored.
  - F: full clear, go to ENTER_A.
- alu_done outside WAIT: ignored.
- disp_value, zero-extended to 2*WIDTH: a in ENTER_A, b in ENTER_B/EXEC/WAIT, result in SHOW. Registered, updating the cycle after the causing event.
- busy=1 exactly in EXEC and WAIT.
- Latency: key E accepted → alu_start high next cycle. alu_done → SHOW and disp_value=result on the following cycle.

Test Plan:
- Keys 1,2,A,3,4,E; alu_done with alu_result=46 three cycles after start → alu_a=12, alu_b=34, alu_op=00, single alu_start pulse; SHOW with disp_value=46, err=0, busy=0.
- Keys 1,2,3 in ENTER_A (MAX_DIGITS=2) → a=12 and the third digit is ignored; then E → no state change.
- Keys 9,D,0,E; alu_done with alu_err=1 → err=1, SHOW. Op key B → ignored. Digit 5 → ENTER_A, a=5, err=0.
- TIMEOUT=16, no alu_done → exactly 16 WAIT cycles, then SHOW with err=1 and disp_value=0. An alu_done arriving afterwards does not change result.
- F pressed during WAIT, alu_done in the same cycle with result 7 → ENTER_A, a=0, result not loaded.
- After result 46: keys B,6,E; done with 40 → alu_a=46, alu_op=01, alu_b=6; disp_value=40. Reset asserted mid-WAIT → immediate ENTER_A, alu_start=0.
